// File: rtl/char_stream_sequencer_pkg.sv
// rtl/char_stream_sequencer_pkg.sv - shared constants, state enum and clog2 helper for the reading stage
package reading_pkg;

    localparam int CHAR_W = 8;
    localparam logic [CHAR_W-1:0] NUL_CHAR = '0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPTURE,
        DRAIN,
        DONE
    } seq_state_e;

    // Bits needed to hold values 0 .. value-1; constant-evaluable for port widths.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/char_stream_sequencer_if.sv
// rtl/char_stream_sequencer_if.sv - reader request bus and downstream character handshake
interface char_stream_sequencer_if #(
    parameter int CHAR_W = 8
);

    logic              rd_enable;
    logic [CHAR_W-1:0] rd_char;
    logic              rd_finished;

    logic [CHAR_W-1:0] out_char;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output rd_enable,
        input  rd_char,
        input  rd_finished,
        output out_char,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_enable,
        output rd_char,
        output rd_finished,
        input  out_char,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/char_stream_sequencer_char_fifo.sv
// rtl/char_stream_sequencer_char_fifo.sv - circular character FIFO with occupancy counter
module char_fifo
    import reading_pkg::*;
#(
    parameter int CHAR_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [CHAR_W-1:0] push_data,
    input  logic              pop,
    output logic [CHAR_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [CHAR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        // A pop in the same cycle frees a slot, so a push into a full FIFO is allowed then.
        push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/char_stream_sequencer.sv
// rtl/char_stream_sequencer.sv - drives the character reader, buffers characters and signals end of stream
module char_stream_sequencer
    import reading_pkg::*;
#(
    parameter int CHAR_W     = reading_pkg::CHAR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_CHARS  = 255,
    localparam int CNT_W     = clog2(MAX_CHARS + 1),
    localparam int OCC_W     = clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    char_stream_sequencer_if.master  bus,
    output logic                     done,
    output logic                     truncated,
    output logic [CNT_W-1:0]         char_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CHARS);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    seq_state_e        state_q, state_d;
    logic              rd_enable_q, rd_enable_d;
    logic              done_q, done_d;
    logic              truncated_q, truncated_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              push, pop;
    logic [CHAR_W-1:0] fifo_head;
    logic              fifo_empty, fifo_full;
    logic [OCC_W-1:0]  occ, occ_next;

    char_fifo #(
        .CHAR_W (CHAR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (bus.rd_char),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (occ)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        truncated_d = truncated_q;
        push        = 1'b0;
        pop         = !fifo_empty && bus.out_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // rd_enable_q already reflects the space check for this cycle.
                if (rd_enable_q) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.rd_finished || (bus.rd_char == CHAR_W'(NUL_CHAR))) begin
                    state_d = DRAIN;
                end else begin
                    push = !fifo_full || pop;
                    if (count_q != MAX_CNT) begin
                        count_d = count_q + 1'b1;
                    end
                    if (count_d == MAX_CNT) begin
                        truncated_d = 1'b1;
                        state_d     = DRAIN;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 1'b1;
        end else if (!push && pop) begin
            occ_next = occ - 1'b1;
        end

        // Request only when next cycle's occupancy leaves a slot; leaving REQ drops it after one cycle.
        rd_enable_d = (state_d == REQ) && (occ_next < FULL_OCC);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rd_enable_q <= 1'b0;
            done_q      <= 1'b0;
            truncated_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_enable_q <= rd_enable_d;
            done_q      <= done_d;
            truncated_q <= truncated_d;
            count_q     <= count_d;
        end
    end

    assign bus.rd_enable = rd_enable_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_char  = fifo_head;
    assign done          = done_q;
    assign truncated     = truncated_q;
    assign char_count    = count_q;

endmodule

// File: tb/tb_char_stream_sequencer.sv
// tb/tb_char_stream_sequencer.sv - scoreboard bench with reader model for two sequencer configurations
module tb_char_stream_sequencer;
    import reading_pkg::*;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]      rst_s, start_s, ready_s;
    logic [7:0]      rdc_s [2];
    logic            rdf_s [2];
    logic [1:0]      en_w, valid_w, done_w, trunc_w;
    logic [1:0][7:0] char_w, cnt_w;

    logic [7:0] rd_stream [2][$];
    logic [7:0] exp_q [2][$];
    int         rd_idx [2];
    int         pulses [2];
    int         pops [2];
    logic       prev_en [2];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=none t=%0t", name, act, $time);
    endtask

    function automatic int max_of(input int g);
        return (g == 0) ? 255 : 5;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int MAXC = (g == 0) ? 255 : 5;
        localparam int CW   = clog2(MAXC + 1);

        char_stream_sequencer_if #(.CHAR_W(8)) bus ();
        logic          done, truncated;
        logic [CW-1:0] char_count;

        char_stream_sequencer #(
            .CHAR_W     (8),
            .FIFO_DEPTH (DEPTH),
            .MAX_CHARS  (MAXC)
        ) dut (
            .clock      (clock),
            .reset_n    (rst_s[g]),
            .start      (start_s[g]),
            .bus        (bus.master),
            .done       (done),
            .truncated  (truncated),
            .char_count (char_count)
        );

        assign bus.rd_char     = rdc_s[g];
        assign bus.rd_finished = rdf_s[g];
        assign bus.out_ready   = ready_s[g];
        assign en_w[g]         = bus.rd_enable;
        assign valid_w[g]      = bus.out_valid;
        assign char_w[g]       = bus.out_char;
        assign done_w[g]       = done;
        assign trunc_w[g]      = truncated;
        assign cnt_w[g]        = 8'(char_count);

        // Reader: a request seen high updates char/finished at the following rising edge.
        always @(negedge clock) begin : rdm
            if (!rst_s[g]) begin
                rdc_s[g]  = 8'h00;
                rdf_s[g]  = 1'b0;
                rd_idx[g] = 0;
            end else if (en_w[g]) begin
                @(posedge clock);
                #1;
                if (rd_idx[g] < rd_stream[g].size()) begin
                    rdc_s[g] = rd_stream[g][rd_idx[g]];
                    rd_idx[g]++;
                end else begin
                    rdf_s[g] = 1'b1;
                end
            end
        end

        always @(negedge clock) begin : mon
            if (!rst_s[g]) begin
                pulses[g]  = 0;
                pops[g]    = 0;
                prev_en[g] = 1'b0;
            end else begin
                if (en_w[g]) begin
                    pulses[g]++;
                    check("en_width", 32'(prev_en[g]), 32'd0);
                    check("en_space", 32'((rd_idx[g] - pops[g]) < DEPTH), 32'd1);
                end
                if (valid_w[g] && ready_s[g]) begin
                    if (exp_q[g].size() == 0) fail_now("sb_extra", 32'(char_w[g]));
                    else check("sb_char", 32'(char_w[g]), 32'(exp_q[g].pop_front()));
                    pops[g]++;
                end
                prev_en[g] = en_w[g];
            end
        end
    end

    task automatic reset_dut(input int g);
        rst_s[g]   = 1'b0;
        start_s[g] = 1'b0;
        ready_s[g] = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        rst_s[g] = 1'b1;
    endtask

    task automatic load(input int g, input logic [7:0] s[$], output int n);
        rd_stream[g] = s;
        exp_q[g].delete();
        n = 0;
        for (int i = 0; i < s.size(); i++) begin
            if (s[i] == 8'h00 || n == max_of(g)) break;
            exp_q[g].push_back(s[i]);
            n++;
        end
    endtask

    task automatic pulse_start(input int g);
        @(posedge clock);
        #2;
        start_s[g] = 1'b1;
        @(posedge clock);
        #2;
        start_s[g] = 1'b0;
    endtask

    // mode 0: always ready, 1: stalled for 20 cycles, 2: random ready
    task automatic run_stream(input int g, input logic [7:0] s[$], input int mode, input int budget);
        int n;
        int p;
        reset_dut(g);
        load(g, s, n);
        pulse_start(g);
        for (int c = 0; c < budget && !done_w[g]; c++) begin
            if (mode == 1 && c == 20) begin
                check("stall_pulses", 32'(pulses[g]), 32'd4);
                check("stall_valid", 32'(valid_w[g]), 32'd1);
            end
            if (mode == 0) ready_s[g] = 1'b1;
            else if (mode == 1) ready_s[g] = (c >= 20);
            else ready_s[g] = 1'($urandom_range(0, 1));
            @(posedge clock);
            #2;
        end
        check("done", 32'(done_w[g]), 32'd1);
        check("char_count", 32'(cnt_w[g]), 32'(n));
        check("truncated", 32'(trunc_w[g]), 32'(n == max_of(g)));
        check("req_pulses", 32'(pulses[g]), 32'((n == max_of(g)) ? n : n + 1));
        check("pops", 32'(pops[g]), 32'(n));
        check("sb_left", 32'(exp_q[g].size()), 32'd0);
        p = pulses[g];
        start_s[g] = 1'b1;
        @(posedge clock);
        #2;
        start_s[g] = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        check("done_sticky", 32'(done_w[g]), 32'd1);
        check("done_no_req", 32'(pulses[g]), 32'(p));
        check("done_empty", 32'(valid_w[g]), 32'd0);
    endtask

    task automatic str_q(input string s, input bit nul, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
        if (nul) q.push_back(8'h00);
    endtask

    task automatic reset_mid_capture();
        logic [7:0] q[$];
        int n;
        int k;
        reset_dut(0);
        str_q("ABCDEFGH", 1'b1, q);
        load(0, q, n);
        pulse_start(0);
        k = 0;
        for (int c = 0; c < 60 && k < 3; c++) begin
            @(negedge clock);
            if (en_w[0]) k++;
        end
        check("mid_third_req", 32'(k), 32'd3);
        @(posedge clock);
        #2;
        check("mid_pre_valid", 32'(valid_w[0]), 32'd1);
        check("mid_pre_count", 32'(cnt_w[0]), 32'd2);
        rst_s[0] = 1'b0;
        exp_q[0].delete();
        #1;
        check("mid_rst_en", 32'(en_w[0]), 32'd0);
        check("mid_rst_valid", 32'(valid_w[0]), 32'd0);
        check("mid_rst_count", 32'(cnt_w[0]), 32'd0);
        repeat (2) @(posedge clock);
        #2;
        rst_s[0]   = 1'b1;
        ready_s[0] = 1'b1;
        repeat (10) @(posedge clock);
        #2;
        check("idle_no_req", 32'(pulses[0]), 32'd0);
        check("idle_valid", 32'(valid_w[0]), 32'd0);
        check("idle_done", 32'(done_w[0]), 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        rst_s   = 2'b00;
        start_s = 2'b00;
        ready_s = 2'b00;
        #2;
        for (int g = 0; g < 2; g++) begin
            check("rst_en", 32'(en_w[g]), 32'd0);
            check("rst_valid", 32'(valid_w[g]), 32'd0);
            check("rst_char", 32'(char_w[g]), 32'd0);
            check("rst_done", 32'(done_w[g]), 32'd0);
            check("rst_trunc", 32'(trunc_w[g]), 32'd0);
            check("rst_count", 32'(cnt_w[g]), 32'd0);
        end

        str_q("<p>hi</p>", 1'b1, q);
        run_stream(0, q, 0, 200);
        run_stream(0, q, 1, 300);
        str_q("abc", 1'b0, q);
        run_stream(0, q, 0, 200);
        str_q("abcdefghi", 1'b1, q);
        run_stream(1, q, 0, 200);
        reset_mid_capture();
        str_q("xyz", 1'b1, q);
        run_stream(0, q, 2, 300);

        for (int r = 0; r < 14; r++) begin
            int g;
            int len;
            g   = $urandom_range(0, 1);
            len = $urandom_range(0, 12);
            q   = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(33, 126)));
            if ($urandom_range(0, 1) == 1) q.push_back(8'h00);
            run_stream(g, q, 2, 600);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/char_stream_sequencer.md
Name: char_stream_sequencer

Overview:
- Sequences the character-stream reader in the reading stage.
- Drives the reader's enable pulse protocol and captures each returned character into a small FIFO.
- Presents characters to the downstream tag/attribute parser over a valid/ready handshake.
- Detects end of stream (reader finished flag or NUL character), counts characters delivered, and signals completion.

Parameters:
- CHAR_W, 8: character width; matches the codebase character-bus macro.
- FIFO_DEPTH, 4: output FIFO entries; power of two, minimum 2.
- MAX_CHARS, 255: hard cap on characters accepted before forced stop. The count width is clog2(MAX_CHARS+1).

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin streaming; sampled only in IDLE.
- rd_enable  out  1  state_enable to the reader.
- rd_char  in  CHAR_W  character from the reader.
- rd_finished  in  1  has_finished from the reader.
- out_char  out  CHAR_W  FIFO head character.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts out_char this cycle.
- done  out  1  stream complete and FIFO drained; sticky.
- truncated  out  1  stop was forced by MAX_CHARS; sticky.
- char_count  out  clog2(MAX_CHARS+1)  characters pushed into the FIFO.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE; FIFO pointers and occupancy clear.
  - rd_enable=0, out_valid=0, out_char=0, done=0, truncated=0, char_count=0.
  - A reset mid-operation discards in-flight and buffered characters. Re-arming the reader itself is outside this block.
- Reader protocol:
  - The reader accepts a request on an edge where enable=1 and its internal busy flag is clear.
  - It updates char or finished at that same edge.
  - Enable must then be low for at least one edge before the next request.
  - This block therefore pulses rd_enable high for exactly one cycle per request.
- FSM states: IDLE, REQ, CAPTURE, DRAIN, DONE.
- IDLE: rd_enable=0. If start=1, go to REQ.
- REQ:
  - rd_enable=1 only if FIFO occupancy < FIFO_DEPTH, then go to CAPTURE.
  - Otherwise rd_enable=0 and remain in REQ (back-pressure stall).
- CAPTURE: rd_enable=0; sample rd_finished and rd_char.
  - rd_finished=1: no push, go to DRAIN.
  - rd_char=0 (NUL): no push, go to DRAIN.
  - Otherwise: push rd_char and increment char_count. If char_count reaches MAX_CHARS, set truncated=1 and go to DRAIN; else go to REQ.
- Throughput and space:
  - Peak rate is 1 character per 2 cycles.
  - At most one request is ever in flight, and REQ checks space, so a CAPTURE push never finds the FIFO full.
- DRAIN: rd_enable=0; wait for FIFO empty, then go to DONE.
- DONE: done=1; terminal until reset; start is ignored.
- FIFO:
  - Circular buffer with wrap-around pointers, plus an occupancy counter of width clog2(FIFO_DEPTH+1).
  - out_char is the head entry, combinational from storage.
  - A pop occurs when out_valid && out_ready.
  - A simultaneous push and pop leaves occupancy unchanged and is legal, including when full: a pop frees the slot the next REQ checks.
  - out_valid stays asserted while occupancy > 0. The head is stable until popped.
- out_ready is honoured in every state, including DRAIN and the cycle of a push.
- A first push into an empty FIFO gives out_valid=1 in the cycle after CAPTURE (1-cycle latency).
- char_count saturates at MAX_CHARS and never wraps.

Decomposition:
- Shared package reading_pkg:
  - CHAR_W constant; NUL_CHAR=0.
  - Sequencer state enum {IDLE, REQ, CAPTURE, DRAIN, DONE}.
  - clog2 helper function.
- One sub-module: char_fifo.
  - Parameters CHAR_W, DEPTH.
  - Ports: clock, reset_n, push, push_data, pop, head, empty, full, count.
  - Instantiated once; the sequencer owns only the FSM, request logic and counters.

Test Plan:
- Stream "<p>hi</p>\0" with out_ready=1 constantly:
  - out_char sequence "<","p",">","h","i","<","/","p",">".
  - char_count=9; rd_enable pulses exactly 10 times, each 1 cycle wide; done=1 after the last pop; truncated=0.
- Same stream with out_ready=0 for 20 cycles, then 1:
  - Occupancy stops at 4 and rd_enable stays 0 while full.
  - All 9 characters arrive in order with no loss or duplication.
- Reader asserts rd_finished after 3 characters "abc":
  - Exactly 3 pops, no 4th push, done=1, char_count=3.
- MAX_CHARS=5 with a 9-character stream:
  - 5 characters delivered, truncated=1, done=1.
  - No rd_enable pulse after the 5th CAPTURE.
- Assert reset_n=0 during CAPTURE with 2 entries buffered:
  - rd_enable, out_valid and char_count are 0 immediately, with no clock edge needed.
  - After release, state is IDLE and start is required to resume.
- Pop on the same cycle as a CAPTURE push, with occupancy 4 and then 1:
  - Occupancy is unchanged; head order is preserved across pointer wrap-around.
